// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the two-requester ALU arbiter.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ADD/SUB unit producing the result, {Z,N,C,V} flags and an error
// strobe for undefined op codes.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              n,
    output logic              c,
    output logic              v,
    output logic              err
);

    localparam int MSB = DATA_W - 1;

    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] diff;

    always_comb begin
        sum    = $signed({1'b0, a}) + $signed({1'b0, b});
        // The borrow out of the zero-extended subtraction is exactly a < b unsigned.
        diff   = $signed({1'b0, a}) - $signed({1'b0, b});
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[MSB:0];
                c      = sum[DATA_W];
                v      = ~(a[MSB] ^ b[MSB]) & (a[MSB] ^ sum[MSB]);
            end
            OP_SUB: begin
                result = diff[MSB:0];
                c      = diff[DATA_W];
                v      = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]);
            end
            default: err = 1'b1;
        endcase
        z = ~err & (result == '0);
        n = result[MSB];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a shared ALU: accept one operation, execute,
// hold the response until taken, and keep per-requester completion counts.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_out,
    output logic [3:0]        rsp_zncv,
    output logic              rsp_err,
    output logic [3:0]        stat_zncv,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t state, state_nxt;

    logic              last_grant;
    logic              grant;
    logic              accept;
    logic              rsp_fire;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic              id_q;

    logic [DATA_W-1:0] alu_result;
    logic              alu_z, alu_n, alu_c, alu_v, alu_err;

    // A tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else if (req1_valid)          grant = 1'b1;
        else                          grant = 1'b0;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = ~reset & ~grant & req0_valid;
                req1_ready = ~reset & grant & req1_valid;
                accept     = req0_ready | req1_ready;
                if (accept) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = ~reset;
                rsp_fire  = ~reset & rsp_ready;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)       last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end

    // Operand capture: only sampled on accept, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= grant ? req1_a  : req0_a;
            b_q  <= grant ? req1_b  : req0_b;
            op_q <= grant ? req1_op : req0_op;
            id_q <= grant;
        end
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .z      (alu_z),
        .n      (alu_n),
        .c      (alu_c),
        .v      (alu_v),
        .err    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id   <= 1'b0;
            rsp_out  <= '0;
            rsp_zncv <= '0;
            rsp_err  <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_id   <= id_q;
            rsp_out  <= alu_result;
            rsp_zncv <= {alu_z, alu_n, alu_c, alu_v};
            rsp_err  <= alu_err;
        end
    end

    // Completion bookkeeping happens at the response handshake only.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_zncv <= '0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else if (rsp_fire) begin
            if (!rsp_err) stat_zncv <= rsp_zncv;
            if (rsp_id) cnt1 <= sat_inc(cnt1);
            else        cnt0 <= sat_inc(cnt0);
        end
    end

endmodule
